// File: rtl/picorv32_mem_responder_if.sv
// PicoRV32 native memory bus between a core-side initiator and the memory responder.
// wait_cycles rides along as a per-request latency hint supplied by the initiator side.
interface picorv32_mem_responder_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned STRB_W = XLEN / 8;

    logic              mem_valid;
    logic              mem_instr;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [1:0]        wait_cycles;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_rdata;
    logic              proto_err;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, wait_cycles,
        input  mem_ready, mem_rdata, proto_err
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, wait_cycles,
        output mem_ready, mem_rdata, proto_err
    );
endinterface

// File: rtl/picorv32_mem_responder.sv
// Coherent word-addressed memory responder for the PicoRV32 native bus with bounded
// programmable wait states and a sticky initiator protocol-violation flag.
module picorv32_mem_responder #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned MAX_WAIT  = 3
) (
    input logic                       clock,
    input logic                       reset,
    picorv32_mem_responder_if.slave   bus
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned DEPTH  = 2 ** ADDR_BITS;
    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WAIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              instr_q, instr_d;
    logic              ready_q, ready_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              proto_q, proto_d;
    logic [CNT_W-1:0]  wait_clamp_c;
    logic              viol_c;

    logic [XLEN-1:0]   mem_q [DEPTH];

    assign wait_clamp_c = (bus.wait_cycles > MAX_W) ? MAX_W : bus.wait_cycles;

    // Initiator must hold the request stable from acceptance through the ready cycle.
    assign viol_c = ((state_q == S_WAIT) || (state_q == S_READY)) &&
                    (!bus.mem_valid || (bus.mem_addr != addr_q) ||
                     (bus.mem_wdata != wdata_q) || (bus.mem_wstrb != wstrb_q) ||
                     (bus.mem_instr != instr_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        instr_d = instr_q;
        proto_d = proto_q | viol_c;
        ready_d = 1'b0;
        rdata_d = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.mem_valid) begin
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.mem_wdata;
                    wstrb_d = bus.mem_wstrb;
                    instr_d = bus.mem_instr;
                    cnt_d   = wait_clamp_c;
                    state_d = (wait_clamp_c != '0) ? S_WAIT : S_READY;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_READY;
                end
            end
            S_READY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so the read data is fetched on entry to READY.
        if (state_d == S_READY) begin
            ready_d = 1'b1;
            if (wstrb_d == '0) begin
                rdata_d = mem_q[addr_d[ADDR_BITS+1:2]];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            instr_q <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            instr_q <= instr_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            proto_q <= proto_d;
        end
    end

    // Store is not cleared by reset; a write whose READY edge meets reset is dropped.
    always_ff @(posedge clock) begin
        if (!reset && (state_q == S_READY) && (wstrb_q != '0)) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb_q[i]) begin
                    mem_q[addr_q[ADDR_BITS+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.proto_err = proto_q;

endmodule

// File: doc/picorv32_mem_responder.md
# picorv32_mem_responder

Memory-side responder for the PicoRV32 native memory interface used in the formal and simulation wrappers. It accepts requests from the core's `mem_valid`/`mem_addr`/`mem_wdata`/`mem_wstrb` port and returns `mem_ready`/`mem_rdata` after a programmable, bounded number of wait states. It is backed by a coherent word-addressed store, so reads return previously written data. It also flags initiator-side protocol violations, replacing the unconstrained `mem_ready`/`mem_rdata` drivers in the wrapper when a consistent memory is needed.

## Interface
- `ADDR_BITS`, 8, word-address bits of the backing store (2**ADDR_BITS 32-bit words)
- `MAX_WAIT`, 3, maximum wait states inserted per request; `wait_cycles` is clamped to this value
- `clock`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `mem_valid`  in  1  request valid from core
- `mem_instr`  in  1  request is an instruction fetch (tracked for protocol check only)
- `mem_addr`  in  32  byte address; bits [1:0] ignored
- `mem_wdata`  in  32  write data
- `mem_wstrb`  in  4  byte write strobes; 0 = read
- `wait_cycles`  in  2  wait states for the request being accepted (free input for formal/bench)
- `mem_ready`  out  1  one-cycle response strobe
- `mem_rdata`  out  32  read data, valid only while `mem_ready`=1
- `proto_err`  out  1  sticky initiator protocol-violation flag

## Operation
- States: IDLE, WAIT, READY.
- Reset: state=IDLE, `mem_ready`=0, `mem_rdata`=0, `proto_err`=0, wait counter=0, latched request fields=0. Store contents are not cleared by reset.
- IDLE: if `mem_valid`=1, latch `mem_addr`, `mem_wdata`, `mem_wstrb`, `mem_instr`. Load counter = min(`wait_cycles`, `MAX_WAIT`). Next state is WAIT if counter>0, else READY.
- WAIT: decrement counter each cycle. Move to READY when the counter reaches 1.
- Word index = latched `mem_addr[ADDR_BITS+1:2]`. Upper address bits alias and are ignored.
- READY: `mem_ready`=1 for exactly one cycle.
  - Read (`mem_wstrb`=0): `mem_rdata` = store word at the index.
  - Write: `mem_rdata`=0, and each byte lane i with strobe bit i set is written with `mem_wdata[8i+7:8i]` at the edge ending the READY cycle.
  - Next state is IDLE.
- Outside READY, `mem_rdata` is driven to 0.
- Protocol check, active in WAIT and READY: `proto_err` is set (sticky until reset) if either of the following occurs:
  - `mem_valid`=0;
  - `mem_addr`, `mem_wdata`, `mem_wstrb` or `mem_instr` differs from the latched value.
  - The response still completes using the latched fields.
- Store arithmetic: byte-lane merge only, no address increment, no wrap handling beyond index truncation.

## Timing
- Request accepted in IDLE cycle N. `mem_ready` is asserted in cycle N+1+W, where W = min(`wait_cycles`@N, `MAX_WAIT`).
- Minimum latency is 1 cycle; maximum is `MAX_WAIT`+1 cycles.
- The cycle after READY is always IDLE. If `mem_valid` is still or again high in that cycle, it is accepted as a new request. This gives back-to-back throughput of one request per W+2 cycles.
- Read-after-write to the same word: a read accepted in the IDLE cycle immediately following a write's READY cycle returns the newly written data.
- `wait_cycles` is sampled only in the accepting IDLE cycle. Changes during WAIT have no effect.
- Reset asserted in any state: next cycle state=IDLE and all outputs are at reset values. A pending write whose READY edge coincides with reset is discarded (the store is not written).

## Test plan
- Zero-wait write then read:
  - Write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, `wait_cycles`=0 -> `mem_ready` high 1 cycle after acceptance.
  - Then read addr 0x10 -> `mem_rdata`=0xDEADBEEF in its ready cycle; `mem_rdata`=0 in all other cycles.
- Byte-lane merge:
  - After the word at 0x10 holds 0xDEADBEEF, write 0x00001100 with wstrb 0x2 -> read returns 0xDEAD11EF.
- Wait clamp and timing:
  - Read with `wait_cycles`=3, `MAX_WAIT`=3 -> `mem_ready` in cycle N+4.
  - Rerun with `MAX_WAIT`=1 -> `mem_ready` in cycle N+2.
  - Changing `wait_cycles` during WAIT does not move the ready cycle.
- Address aliasing, `ADDR_BITS`=8:
  - Write 0x12345678 to 0x0000_0004, then read 0x0000_0404 -> 0x12345678.
  - Read 0x0000_0007 -> same word.
- Protocol violation:
  - Drop `mem_valid` in the first WAIT cycle -> `proto_err`=1 next cycle and stays 1.
  - `mem_ready` still pulses at the scheduled cycle.
  - Separately, changing `mem_addr` mid-WAIT also sets `proto_err`.
- Reset mid-operation:
  - Assert `reset` during the READY cycle of a write of 0xAAAAAAAA to 0x20 (previously 0x0) -> `mem_ready`=0 next cycle, state IDLE.
  - A subsequent read of 0x20 returns 0x0.
